board_responder: RTL and testbench
==================================

# board_responder

Defender-side board for BattleChip: holds one player's fleet placement and answers incoming shots with hit/miss/sunk results. It produces the `fired[99:0]` cell map and `ships[4:0]` afloat mask in exactly the encoding the `ai` targeting block consumes. It therefore closes the loop between the shooter (`ai`) and the target board.

## Interface
Parameters:
- `BOARD_DIM`, default 10: board edge; cells are indexed `row*10+col`, 0..99.
- `NUM_SHIPS`, default 5: fleet size. Ship lengths by id 0..4 are 5, 4, 3, 3, 2.

Ports:
- `clk`  in  1: single clock; everything is posedge.
- `rst_n`  in  1: synchronous, active-low reset.
- `place_valid`  in  1: placement request.
- `place_ship`  in  3: ship id 0..4.
- `place_origin`  in  7: top/left cell index.
- `place_vertical`  in  1: 1 means extend down (+10 per cell); 0 means extend right (+1 per cell).
- `place_ready`  out  1: placement request can be accepted.
- `place_done`  out  1: one-cycle pulse ending a placement.
- `place_ok`  out  1: valid with `place_done`; 1 means the ship was written.
- `shot_valid`  in  1: shot request.
- `shot_index`  in  7: target cell.
- `shot_ready`  out  1: shot request can be accepted.
- `result_valid`  out  1: one-cycle pulse with the shot result.
- `result_hit`  out  1: shot hit a ship.
- `result_sunk`  out  1: the hit sank the ship.
- `result_ship`  out  3: id of the ship hit, else 0.
- `result_repeat`  out  1: cell was already fired, or index ≥ 100.
- `fired`  out  100: bit i means cell i has been shot.
- `hits`  out  100: bit i means cell i was shot and hit.
- `ships`  out  5: bit i means ship i is afloat.
- `armed`  out  1: all 5 ships are placed.
- `game_over`  out  1: sticky; set when `ships == 0`.

## Operation
- Storage: a 100×3-bit cell map (0 = empty, id+1 = ship id), plus per-ship 3-bit remaining-hit counters and a placed mask.
- States: IDLE, P_CHECK, P_WRITE, P_DONE, S_LOOKUP, S_UPDATE, S_RESULT, OVER.
- IDLE:
  - `place_ready = !armed`.
  - `shot_ready = armed && !game_over`.
  - Placement and shots never compete, because their ready signals are mutually exclusive.
- Placement accept (`place_valid && place_ready`): latch ship, origin, direction and length.
  - Reject to P_DONE (`place_ok = 0`) if any of these hold: id > 4, origin > 99, ship already placed, horizontal with `col + len > 10`, vertical with `row + len > 10`.
  - Otherwise go to P_CHECK.
- P_CHECK: examine one cell per cycle, k = 0..len-1. Any occupied cell goes to P_DONE with `ok = 0`. Clean completion goes to P_WRITE.
- P_WRITE: write id+1 to one cell per cycle, k = 0..len-1. Then load the counter with len, set the placed bit, and go to P_DONE with `ok = 1`.
- P_DONE: pulse `place_done`, return to IDLE. `armed` rises the cycle after the 5th success.
- Shot accept: latch the index and go to S_LOOKUP. S_LOOKUP reads the cell id and the fired bit.
- S_UPDATE:
  - If the index is ≥ 100 or the cell is already fired: set `repeat = 1`; no state change.
  - Else: set `fired[i]`.
  - If the cell is occupied: set `hits[i]` and decrement the counter. If the counter reaches 0, clear `ships[id]` and set `sunk`.
- S_RESULT: pulse `result_valid`. Go to OVER if `ships == 0`, else to IDLE.
- OVER: all readies are 0. Exit only by reset.

## Timing
- Reset values:
  - All control/handshake outputs are 0: `place_done`, `place_ok`, `result_*`, `armed`, `game_over`, `shot_ready`.
  - `fired = 0`, `hits = 0`, `ships = 5'b11111`, `place_ready = 1`.
  - Cell map, counters and placed mask are cleared.
- Reset mid-placement or mid-shot aborts the operation; no partial write survives.
- Placement, accepted at edge T:
  - Reject: `place_done` during cycle T+1.
  - Overlap found at step k: `place_done` at T+k+2.
  - Success: `place_done` at T+2·len+1.
- Shot, accepted at edge T: `result_valid` during cycle T+3.
  - `fired`, `hits` and `ships` already reflect the shot in that cycle.
  - The next shot can be accepted at T+4.
- `result_*` fields are 0 whenever `result_valid` is 0.
- `game_over` rises in the cycle after the final `result_valid`.
- Inputs other than valids are sampled only on the accept edge.

## Structure
- `battlechip_pkg` holds:
  - `BOARD_DIM`, `BOARD_CELLS = 100`, `NUM_SHIPS`.
  - `ship_id_t` (3-bit).
  - `SHIP_LEN` constant array {5, 4, 3, 3, 2}.
  - The state enum.
- The `ai` block shares the same package for the `fired`/`ships` widths.
- One sub-module: `cell_to_rowcol`, a combinational 7-bit index → 4-bit row, 4-bit col (constant divide by 10). It is used for the bounds check and shared with the `ai` block.

## Test plan
- Place ids 0..4 at origins 0, 10, 20, 30, 40, all horizontal → five `place_ok = 1` pulses. Ship 0 (len 5) has `place_done` 11 cycles after accept. `armed = 1`.
- Place ship 0 horizontal at 7 → `place_done` at T+1, `ok = 0`. Then place ship 1 vertical at 0 over placed ship 0 → overlap detected at k=0, `ok = 0`.
- Armed board as in the first scenario; shot 55 → miss. Result at T+3 with `fired[55] = 1`, `hits = 0`, `ships = 5'b11111`.
- Shots 40, 41 → second result has `hit = 1`, `sunk = 1`, `ship = 4`, `ships = 5'b01111`.
- Repeat shot 41, then shot 120 → both give `repeat = 1`; `fired` and `ships` unchanged.
- Shoot all 17 ship cells → the last result has `sunk = 1`, `ships = 0`. `game_over = 1` next cycle; `shot_ready` stays 0. Assert `rst_n = 0` for one cycle → all reset values restored.

Source files
------------

// File: rtl/battlechip_pkg.sv
// Shared BattleChip definitions: board geometry, fleet makeup and the
// defender-board state encoding. The ai targeting block uses the same package.
package battlechip_pkg;

    localparam int BOARD_DIM   = 10;
    localparam int BOARD_CELLS = 100;
    localparam int NUM_SHIPS   = 5;

    typedef logic [2:0] ship_id_t;

    // Ship length by id: carrier, battleship, cruiser, submarine, destroyer.
    localparam logic [2:0] SHIP_LEN [NUM_SHIPS] = '{3'd5, 3'd4, 3'd3, 3'd3, 3'd2};

    typedef enum logic [2:0] {
        IDLE,
        P_CHECK,
        P_WRITE,
        P_DONE,
        S_LOOKUP,
        S_UPDATE,
        S_RESULT,
        OVER
    } state_t;

    // Length of a ship id; ids outside the fleet report length 0.
    function automatic logic [2:0] ship_len(input ship_id_t id);
        return (id < 3'(NUM_SHIPS)) ? SHIP_LEN[id] : 3'd0;
    endfunction

endpackage

// File: rtl/board_responder_cell_to_rowcol.sv
// Splits a linear cell index (row*10+col) into row and column.
// Indices up to 127 are accepted; rows 10..12 signal off-board origins.
module cell_to_rowcol
    import battlechip_pkg::*;
(
    input  logic [6:0] index,
    output logic [3:0] row,
    output logic [3:0] col
);

    assign row = 4'(index / 7'(BOARD_DIM));
    assign col = 4'(index % 7'(BOARD_DIM));

endmodule

// File: rtl/board_responder.sv
// Defender board: stores one fleet placement, walks each placement one cell
// per cycle (check pass, then write pass) and answers shots with
// hit/miss/sunk/repeat results plus the fired/hits/ships maps for the ai.
module board_responder #(
    parameter int BOARD_DIM = 10,
    parameter int NUM_SHIPS = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             place_valid,
    input  logic [2:0]                       place_ship,
    input  logic [6:0]                       place_origin,
    input  logic                             place_vertical,
    output logic                             place_ready,
    output logic                             place_done,
    output logic                             place_ok,
    input  logic                             shot_valid,
    input  logic [6:0]                       shot_index,
    output logic                             shot_ready,
    output logic                             result_valid,
    output logic                             result_hit,
    output logic                             result_sunk,
    output logic [2:0]                       result_ship,
    output logic                             result_repeat,
    output logic [BOARD_DIM*BOARD_DIM-1:0]   fired,
    output logic [BOARD_DIM*BOARD_DIM-1:0]   hits,
    output logic [NUM_SHIPS-1:0]             ships,
    output logic                             armed,
    output logic                             game_over
);

    import battlechip_pkg::*;

    localparam int CELLS = BOARD_DIM * BOARD_DIM;

    state_t               state;
    logic [2:0]           cell_map [CELLS];
    logic [2:0]           remain   [NUM_SHIPS];
    logic [NUM_SHIPS-1:0] placed;

    // Latched placement request and walk position
    ship_id_t   p_ship;
    logic [6:0] p_origin;
    logic [6:0] p_idx;
    logic       p_vert;
    logic [2:0] p_len;
    logic [2:0] p_k;
    logic [6:0] p_step;

    // Latched shot and the looked-up cell contents
    logic [6:0] s_idx;
    logic [2:0] s_cell;
    logic       s_fired;
    logic       s_oob;
    ship_id_t   hit_id;

    logic [3:0] org_row;
    logic [3:0] org_col;
    logic       id_ok;
    logic [2:0] in_len;
    logic [4:0] span;
    logic       place_reject;

    cell_to_rowcol u_origin_rc (
        .index (place_origin),
        .row   (org_row),
        .col   (org_col)
    );

    assign place_ready = (state == IDLE) && !armed;
    assign shot_ready  = (state == IDLE) && armed && !game_over;
    assign p_step      = p_vert ? 7'(BOARD_DIM) : 7'd1;
    assign hit_id      = s_cell - 3'd1;

    // Reject checks that need no board access: bad id, off-board origin,
    // duplicate ship, or a ship that would run off the edge.
    always_comb begin
        id_ok        = place_ship < 3'(NUM_SHIPS);
        in_len       = ship_len(place_ship);
        span         = place_vertical ? (5'(org_row) + 5'(in_len))
                                      : (5'(org_col) + 5'(in_len));
        place_reject = !id_ok
                    || (place_origin >= 7'(CELLS))
                    || (id_ok && placed[place_ship])
                    || (span > 5'(BOARD_DIM));
    end

    // Board controller: placement walk, shot lookup/update and result pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            place_done    <= 1'b0;
            place_ok      <= 1'b0;
            result_valid  <= 1'b0;
            result_hit    <= 1'b0;
            result_sunk   <= 1'b0;
            result_ship   <= '0;
            result_repeat <= 1'b0;
            fired         <= '0;
            hits          <= '0;
            ships         <= '1;
            armed         <= 1'b0;
            game_over     <= 1'b0;
            placed        <= '0;
            p_ship        <= '0;
            p_origin      <= '0;
            p_idx         <= '0;
            p_vert        <= 1'b0;
            p_len         <= '0;
            p_k           <= '0;
            s_idx         <= '0;
            s_cell        <= '0;
            s_fired       <= 1'b0;
            s_oob         <= 1'b0;
            for (int i = 0; i < CELLS; i++) cell_map[i] <= '0;
            for (int i = 0; i < NUM_SHIPS; i++) remain[i] <= '0;
        end else begin
            // Pulsed outputs fall back to zero unless a state raises them.
            place_done    <= 1'b0;
            place_ok      <= 1'b0;
            result_valid  <= 1'b0;
            result_hit    <= 1'b0;
            result_sunk   <= 1'b0;
            result_ship   <= '0;
            result_repeat <= 1'b0;

            case (state)
                IDLE: begin
                    if (place_valid && place_ready) begin
                        p_ship   <= place_ship;
                        p_origin <= place_origin;
                        p_idx    <= place_origin;
                        p_vert   <= place_vertical;
                        p_len    <= in_len;
                        p_k      <= '0;
                        if (place_reject) begin
                            place_done <= 1'b1;
                            state      <= P_DONE;
                        end else begin
                            state <= P_CHECK;
                        end
                    end else if (shot_valid && shot_ready) begin
                        s_idx <= shot_index;
                        state <= S_LOOKUP;
                    end
                end

                P_CHECK: begin
                    if (cell_map[p_idx] != 3'd0) begin
                        place_done <= 1'b1;
                        state      <= P_DONE;
                    end else if (p_k == p_len - 3'd1) begin
                        p_k   <= '0;
                        p_idx <= p_origin;
                        state <= P_WRITE;
                    end else begin
                        p_k   <= p_k + 3'd1;
                        p_idx <= p_idx + p_step;
                    end
                end

                P_WRITE: begin
                    cell_map[p_idx] <= p_ship + 3'd1;
                    if (p_k == p_len - 3'd1) begin
                        remain[p_ship] <= p_len;
                        placed[p_ship] <= 1'b1;
                        place_done     <= 1'b1;
                        place_ok       <= 1'b1;
                        state          <= P_DONE;
                    end else begin
                        p_k   <= p_k + 3'd1;
                        p_idx <= p_idx + p_step;
                    end
                end

                P_DONE: begin
                    if (&placed) armed <= 1'b1;
                    state <= IDLE;
                end

                S_LOOKUP: begin
                    s_oob   <= s_idx >= 7'(CELLS);
                    s_cell  <= (s_idx < 7'(CELLS)) ? cell_map[s_idx] : 3'd0;
                    s_fired <= (s_idx < 7'(CELLS)) ? fired[s_idx] : 1'b0;
                    state   <= S_UPDATE;
                end

                S_UPDATE: begin
                    if (s_oob || s_fired) begin
                        result_repeat <= 1'b1;
                    end else begin
                        fired[s_idx] <= 1'b1;
                        if (s_cell != 3'd0) begin
                            hits[s_idx]    <= 1'b1;
                            result_hit     <= 1'b1;
                            result_ship    <= hit_id;
                            remain[hit_id] <= remain[hit_id] - 3'd1;
                            if (remain[hit_id] == 3'd1) begin
                                ships[hit_id] <= 1'b0;
                                result_sunk   <= 1'b1;
                            end
                        end
                    end
                    result_valid <= 1'b1;
                    state        <= S_RESULT;
                end

                S_RESULT: begin
                    if (ships == '0) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= IDLE;
                    end
                end

                OVER: state <= OVER;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_responder.sv
// Bench for board_responder: directed placement/shot scenarios followed by
// randomized placements and shot sequences checked against a board model.
module tb_board_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        place_valid;
    logic [2:0]  place_ship;
    logic [6:0]  place_origin;
    logic        place_vertical;
    logic        place_ready;
    logic        place_done;
    logic        place_ok;
    logic        shot_valid;
    logic [6:0]  shot_index;
    logic        shot_ready;
    logic        result_valid;
    logic        result_hit;
    logic        result_sunk;
    logic [2:0]  result_ship;
    logic        result_repeat;
    logic [99:0] fired;
    logic [99:0] hits;
    logic [4:0]  ships;
    logic        armed;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Board model: ship id per cell (-1 empty), remaining hits, placed mask.
    int       m_map [100];
    int       m_rem [5];
    bit [4:0] m_placed;
    bit [99:0] m_fired;
    bit [99:0] m_hits;
    bit [4:0] m_ships;
    int       LEN [5] = '{5, 4, 3, 3, 2};

    board_responder #(.BOARD_DIM(10), .NUM_SHIPS(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .place_valid    (place_valid),
        .place_ship     (place_ship),
        .place_origin   (place_origin),
        .place_vertical (place_vertical),
        .place_ready    (place_ready),
        .place_done     (place_done),
        .place_ok       (place_ok),
        .shot_valid     (shot_valid),
        .shot_index     (shot_index),
        .shot_ready     (shot_ready),
        .result_valid   (result_valid),
        .result_hit     (result_hit),
        .result_sunk    (result_sunk),
        .result_ship    (result_ship),
        .result_repeat  (result_repeat),
        .fired          (fired),
        .hits           (hits),
        .ships          (ships),
        .armed          (armed),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 100; i++) m_map[i] = -1;
        for (int i = 0; i < 5; i++) m_rem[i] = 0;
        m_placed = '0;
        m_fired  = '0;
        m_hits   = '0;
        m_ships  = 5'b11111;
    endtask

    // Bounds and duplicate rule only (no occupancy).
    function automatic bit model_legal(input int id, input int org, input bit vert);
        if (id > 4 || org > 99) return 0;
        if (m_placed[id]) return 0;
        if (vert) return (org / 10 + LEN[id]) <= 10;
        return (org % 10 + LEN[id]) <= 10;
    endfunction

    // First occupied step along the ship, or -1 when the path is clear.
    function automatic int model_overlap(input int id, input int org, input bit vert);
        for (int k = 0; k < LEN[id]; k++)
            if (m_map[org + k * (vert ? 10 : 1)] >= 0) return k;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        place_valid = 1'b0;
        shot_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic place(input int id, input int org, input bit vert, input string name);
        int exp_lat;
        bit exp_ok;
        int n;
        int ov;
        exp_ok = 0;
        if (!model_legal(id, org, vert)) begin
            exp_lat = 1;
        end else begin
            ov = model_overlap(id, org, vert);
            if (ov >= 0) begin
                exp_lat = ov + 2;
            end else begin
                for (int k = 0; k < LEN[id]; k++) m_map[org + k * (vert ? 10 : 1)] = id;
                m_rem[id] = LEN[id];
                m_placed[id] = 1'b1;
                exp_ok = 1;
                exp_lat = 2 * LEN[id] + 1;
            end
        end
        n = 0;
        while (!place_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!place_ready) begin
            $display("FAIL %s ready: place_ready=%0b required 1", name, place_ready);
            n_fail++;
            return;
        end
        place_valid = 1'b1;
        place_ship = 3'(id);
        place_origin = 7'(org);
        place_vertical = vert;
        @(posedge clk);
        @(negedge clk);
        place_valid = 1'b0;
        place_ship = 3'($urandom);
        place_origin = 7'($urandom);
        place_vertical = 1'($urandom);
        n = 1;
        while (!place_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!place_done || n != exp_lat) begin
            $display("FAIL %s latency: place_done=%0b after %0d cycles, required at %0d", name, place_done, n, exp_lat);
            n_fail++;
        end
        n_checks++;
        if (place_ok !== exp_ok) begin
            $display("FAIL %s ok: place_ok=%0b required %0b", name, place_ok, exp_ok);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (place_done !== 1'b0 || armed !== (m_placed == 5'h1f) || place_ready !== (m_placed != 5'h1f)) begin
            $display("FAIL %s after: done=%0b armed=%0b ready=%0b required 0,%0b,%0b", name, place_done, armed,
                     place_ready, (m_placed == 5'h1f), (m_placed != 5'h1f));
            n_fail++;
        end
    endtask

    task automatic shoot(input int idx, input string name);
        bit e_rep, e_hit, e_sunk;
        int e_ship;
        int n;
        e_rep = 0; e_hit = 0; e_sunk = 0; e_ship = 0;
        if (idx > 99 || m_fired[idx]) begin
            e_rep = 1;
        end else begin
            m_fired[idx] = 1'b1;
            if (m_map[idx] >= 0) begin
                e_hit = 1;
                e_ship = m_map[idx];
                m_hits[idx] = 1'b1;
                m_rem[e_ship]--;
                if (m_rem[e_ship] == 0) begin
                    m_ships[e_ship] = 1'b0;
                    e_sunk = 1;
                end
            end
        end
        n = 0;
        while (!shot_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!shot_ready) begin
            $display("FAIL %s ready: shot_ready=%0b required 1", name, shot_ready);
            n_fail++;
            return;
        end
        shot_valid = 1'b1;
        shot_index = 7'(idx);
        @(posedge clk);
        @(negedge clk);
        shot_valid = 1'b0;
        shot_index = 7'($urandom);
        n = 1;
        n_checks++;
        if (result_valid !== 1'b0 || result_hit !== 1'b0 || result_sunk !== 1'b0 || result_ship !== 3'd0 ||
            result_repeat !== 1'b0) begin
            $display("FAIL %s idle fields: valid=%0b hit=%0b sunk=%0b ship=%0d rep=%0b required all 0", name,
                     result_valid, result_hit, result_sunk, result_ship, result_repeat);
            n_fail++;
        end
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!result_valid || n != 3) begin
            $display("FAIL %s latency: result_valid=%0b after %0d cycles, required at 3", name, result_valid, n);
            n_fail++;
        end
        n_checks++;
        if (result_hit !== e_hit || result_sunk !== e_sunk || result_ship !== 3'(e_ship) || result_repeat !== e_rep) begin
            $display("FAIL %s result: hit=%0b sunk=%0b ship=%0d rep=%0b required %0b %0b %0d %0b", name, result_hit,
                     result_sunk, result_ship, result_repeat, e_hit, e_sunk, e_ship, e_rep);
            n_fail++;
        end
        n_checks++;
        if (fired !== m_fired || hits !== m_hits || ships !== m_ships) begin
            $display("FAIL %s maps: fired=%h hits=%h ships=%b required %h %h %b", name, fired, hits, ships,
                     m_fired, m_hits, m_ships);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || game_over !== (m_ships == 0) || shot_ready !== (m_ships != 0)) begin
            $display("FAIL %s after: valid=%0b game_over=%0b shot_ready=%0b required 0 %0b %0b", name, result_valid,
                     game_over, shot_ready, (m_ships == 0), (m_ships != 0));
            n_fail++;
        end
    endtask

    task automatic test_reset(input string name);
        n_checks++;
        if (place_done !== 0 || place_ok !== 0 || result_valid !== 0 || result_hit !== 0 || result_sunk !== 0 ||
            result_ship !== 0 || result_repeat !== 0) begin
            $display("FAIL %s pulses: done=%0b ok=%0b rv=%0b hit=%0b sunk=%0b ship=%0d rep=%0b required all 0", name,
                     place_done, place_ok, result_valid, result_hit, result_sunk, result_ship, result_repeat);
            n_fail++;
        end
        n_checks++;
        if (armed !== 0 || game_over !== 0 || shot_ready !== 0 || place_ready !== 1) begin
            $display("FAIL %s control: armed=%0b over=%0b shot_ready=%0b place_ready=%0b required 0 0 0 1", name,
                     armed, game_over, shot_ready, place_ready);
            n_fail++;
        end
        n_checks++;
        if (fired !== '0 || hits !== '0 || ships !== 5'b11111) begin
            $display("FAIL %s maps: fired=%h hits=%h ships=%b required 0 0 11111", name, fired, hits, ships);
            n_fail++;
        end
    endtask

    task automatic test_placement();
        place(0, 0, 0, "place_s0");
        place(0, 7, 0, "reject_s0_dup_edge");
        place(1, 0, 1, "overlap_s1_k0");
        place(5, 50, 0, "reject_bad_id");
        place(2, 100, 0, "reject_bad_origin");
        place(3, 98, 1, "reject_vert_edge");
        for (int i = 1; i < 5; i++) place(i, i * 10, 0, "place_row");
    endtask

    task automatic test_shots();
        shoot(55, "shot_miss55");
        shoot(40, "shot_hit40");
        shoot(41, "shot_sink41");
        shoot(41, "shot_repeat41");
        shoot(120, "shot_oob120");
    endtask

    // Random mix of ship cells (shuffled) and arbitrary indices until the fleet sinks.
    task automatic test_random_game(input string name);
        int cells[$];
        int j, t, guard;
        for (int i = 0; i < 100; i++) if (m_map[i] >= 0) cells.push_back(i);
        for (int i = cells.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = cells[i]; cells[i] = cells[j]; cells[j] = t;
        end
        guard = 0;
        while (m_ships != 0 && guard < 300) begin
            if ($urandom_range(0, 3) == 0 || cells.size() == 0) shoot($urandom_range(0, 127), name);
            else shoot(cells.pop_front(), name);
            guard++;
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (game_over !== 1 || shot_ready !== 0 || place_ready !== 0) begin
                $display("FAIL %s over: game_over=%0b shot_ready=%0b place_ready=%0b required 1 0 0", name,
                         game_over, shot_ready, place_ready);
                n_fail++;
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        while (!place_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        place_valid = 1'b1;
        place_ship = 3'd0;
        place_origin = 7'd0;
        place_vertical = 1'b0;
        @(posedge clk);
        @(negedge clk);
        place_valid = 1'b0;
        repeat (7) @(negedge clk);
        do_reset();
        test_reset("mid_reset_values");
        place(1, 0, 0, "after_abort_reuse");
        place(0, 0, 1, "after_abort_s0_free");
    endtask

    task automatic test_random_place();
        int id, org;
        bit vert;
        for (int a = 0; a < 60 && m_placed != 5'h1f; a++) begin
            id = $urandom_range(0, 5);
            org = $urandom_range(0, 104);
            vert = 1'($urandom);
            place(id, org, vert, "rand_place");
        end
        for (int s = 0; s < 5; s++) begin
            if (!m_placed[s]) begin
                for (int o = 0; o < 200 && !m_placed[s]; o++) begin
                    if (model_legal(s, o % 100, o >= 100) && model_overlap(s, o % 100, o >= 100) < 0)
                        place(s, o % 100, o >= 100, "fill_place");
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        place_valid = 1'b0;
        place_ship = '0;
        place_origin = '0;
        place_vertical = 1'b0;
        shot_valid = 1'b0;
        shot_index = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        test_reset("reset");
        test_placement();
        test_shots();
        test_random_game("game1");
        do_reset();
        test_reset("reset_after_game");
        test_mid_reset();
        do_reset();
        test_random_place();
        test_random_game("game2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
